// File: rtl/voice_pkg.sv
// Shared definitions for the polyphonic voice allocator: command layout,
// opcodes, field widths, FSM states and the velocity-to-amplitude mapping.
package voice_pkg;

   localparam logic [1:0] OP_NOP    = 2'b00;
   localparam logic [1:0] OP_ON     = 2'b01;
   localparam logic [1:0] OP_OFF    = 2'b10;
   localparam logic [1:0] OP_ALLOFF = 2'b11;

   localparam int NOTE_W = 7;
   localparam int VEL_W  = 7;
   localparam int AMP_W  = 10;

   // Command word bit-field positions (LSB of each field)
   localparam int CMD_OP_LSB   = 14;
   localparam int CMD_NOTE_LSB = 7;
   localparam int CMD_VEL_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_APPLY = 2'd2
   } state_t;

   // Stretch 7-bit velocity to 10-bit amplitude so 127 maps to full scale
   function automatic logic [AMP_W-1:0] vel_to_amp(input logic [VEL_W-1:0] vel);
      return {vel, vel[VEL_W-1 -: 3]};
   endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice slot: gate/note/amp/stamp registers, allocation age and the
// one-cycle retrigger pulse that resets the oscillator phase.
module voice_slot
   import voice_pkg::*;
#(
   parameter int STAMP_W = 8
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [STAMP_W-1:0] i_stamp_ctr,
   input  logic               i_set,
   input  logic               i_clr,
   input  logic [NOTE_W-1:0]  i_note,
   input  logic [AMP_W-1:0]   i_amp,
   output logic               o_gate,
   output logic [NOTE_W-1:0]  o_note,
   output logic [AMP_W-1:0]   o_amp,
   output logic [STAMP_W-1:0] o_age,
   output logic               o_retrig
);

   logic               r_gate;
   logic [NOTE_W-1:0]  r_note;
   logic [AMP_W-1:0]   r_amp;
   logic [STAMP_W-1:0] r_stamp;
   logic               r_retrig;

   // Commit a note-on (gate, note, amp, stamp, retrig) or clear the gate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gate   <= 1'b0;
         r_note   <= '0;
         r_amp    <= '0;
         r_stamp  <= '0;
         r_retrig <= 1'b0;
      end else begin
         r_retrig <= i_set;
         if (i_set) begin
            r_gate  <= 1'b1;
            r_note  <= i_note;
            r_amp   <= i_amp;
            r_stamp <= i_stamp_ctr;
         end else if (i_clr) begin
            r_gate  <= 1'b0;
         end
      end
   end

   // Modular age keeps ordering correct across stamp counter wrap
   assign o_age    = i_stamp_ctr - r_stamp;
   assign o_gate   = r_gate;
   assign o_note   = r_note;
   assign o_amp    = r_amp;
   assign o_retrig = r_retrig;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: accepts note commands, scans the slots one per
// cycle to pick a matching, free or oldest voice, then commits in APPLY.
module voice_allocator
   import voice_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int STAMP_W    = 8
)
(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [15:0]                  cmd_data,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   output logic [NUM_VOICES-1:0]        voice_gate,
   output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
   output logic [AMP_W*NUM_VOICES-1:0]  voice_amp,
   output logic [NUM_VOICES-1:0]        voice_retrig,
   output logic                         steal
);

   localparam int               IDX_W    = $clog2(NUM_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

   state_t                r_state, w_state_next;
   logic [IDX_W-1:0]      r_idx;
   logic [NOTE_W-1:0]     r_cmd_note;
   logic [AMP_W-1:0]      r_cmd_amp;
   logic                  r_is_on;
   logic                  r_match_found, r_free_found;
   logic [IDX_W-1:0]      r_match_idx, r_free_idx, r_old_idx;
   logic [STAMP_W-1:0]    r_old_age, r_stamp_ctr;
   logic [NUM_VOICES-1:0] r_match_mask;
   logic                  r_steal;

   logic [1:0]            w_op;
   logic [NOTE_W-1:0]     w_in_note;
   logic [VEL_W-1:0]      w_in_vel;
   logic                  w_accept, w_start, w_alloff, w_apply;
   logic [IDX_W-1:0]      w_sel_idx;
   logic [NUM_VOICES-1:0] w_set, w_clr;
   logic [NOTE_W-1:0]     w_note_arr [NUM_VOICES];
   logic [STAMP_W-1:0]    w_age_arr  [NUM_VOICES];

   assign w_op      = cmd_data[CMD_OP_LSB +: 2];
   assign w_in_note = cmd_data[CMD_NOTE_LSB +: NOTE_W];
   assign w_in_vel  = cmd_data[CMD_VEL_LSB +: VEL_W];
   assign cmd_ready = (r_state == ST_IDLE);
   assign w_accept  = cmd_ready && cmd_valid;
   assign w_apply   = (r_state == ST_APPLY);
   assign steal     = r_steal;

   // Matching voice wins, then lowest free slot, then the oldest voice
   assign w_sel_idx = r_match_found ? r_match_idx :
                      (r_free_found ? r_free_idx : r_old_idx);

   // Decode an accepted command into all-off or scan start
   always_comb begin
      w_start  = 1'b0;
      w_alloff = 1'b0;
      if (w_accept) begin
         case (w_op)
            OP_NOP:    ;
            OP_ALLOFF: w_alloff = 1'b1;
            default:   w_start  = 1'b1;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start) w_state_next = ST_SCAN;
         ST_SCAN:  if (r_idx == LAST_IDX) w_state_next = ST_APPLY;
         ST_APPLY: w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Latch command, track best candidates during the scan, bump stamp on commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx         <= '0;
         r_cmd_note    <= '0;
         r_cmd_amp     <= '0;
         r_is_on       <= 1'b0;
         r_match_found <= 1'b0;
         r_free_found  <= 1'b0;
         r_match_idx   <= '0;
         r_free_idx    <= '0;
         r_old_idx     <= '0;
         r_old_age     <= '0;
         r_match_mask  <= '0;
         r_stamp_ctr   <= '0;
         r_steal       <= 1'b0;
      end else begin
         r_steal <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_cmd_note    <= w_in_note;
                  r_cmd_amp     <= vel_to_amp(w_in_vel);
                  // Velocity-0 note-on behaves as note-off
                  r_is_on       <= (w_op == OP_ON) && (w_in_vel != '0);
                  r_idx         <= '0;
                  r_match_found <= 1'b0;
                  r_free_found  <= 1'b0;
                  r_match_mask  <= '0;
               end
            end
            ST_SCAN: begin
               if (voice_gate[r_idx] && (w_note_arr[r_idx] == r_cmd_note)) begin
                  r_match_mask[r_idx] <= 1'b1;
                  if (!r_match_found) begin
                     r_match_found <= 1'b1;
                     r_match_idx   <= r_idx;
                  end
               end
               if (!voice_gate[r_idx] && !r_free_found) begin
                  r_free_found <= 1'b1;
                  r_free_idx   <= r_idx;
               end
               // Strict compare keeps the lowest index on an age tie
               if ((r_idx == '0) || (w_age_arr[r_idx] > r_old_age)) begin
                  r_old_idx <= r_idx;
                  r_old_age <= w_age_arr[r_idx];
               end
               if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
            end
            ST_APPLY: begin
               if (r_is_on) begin
                  r_stamp_ctr <= r_stamp_ctr + 1'b1;
                  r_steal     <= !r_match_found && !r_free_found;
               end
            end
            default: ;
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
      assign w_set[gi] = w_apply && r_is_on && (w_sel_idx == IDX_W'(gi));
      assign w_clr[gi] = w_alloff || (w_apply && !r_is_on && r_match_mask[gi]);
      assign voice_note[gi*NOTE_W +: NOTE_W] = w_note_arr[gi];

      voice_slot #(
         .STAMP_W     (STAMP_W)
      ) u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_stamp_ctr (r_stamp_ctr),
         .i_set       (w_set[gi]),
         .i_clr       (w_clr[gi]),
         .i_note      (r_cmd_note),
         .i_amp       (r_cmd_amp),
         .o_gate      (voice_gate[gi]),
         .o_note      (w_note_arr[gi]),
         .o_amp       (voice_amp[gi*AMP_W +: AMP_W]),
         .o_age       (w_age_arr[gi]),
         .o_retrig    (voice_retrig[gi])
      );
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (NUM_VOICES=4): expected values are
// hand-derived from the command words and the slot-choice rules.
module tb_voice_allocator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cmd_data = '0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  voice_gate;
   logic [27:0] voice_note;
   logic [39:0] voice_amp;
   logic [3:0]  voice_retrig;
   logic        steal;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   voice_allocator #(.NUM_VOICES(4), .STAMP_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_data     (cmd_data),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .voice_gate   (voice_gate),
      .voice_note   (voice_note),
      .voice_amp    (voice_amp),
      .voice_retrig (voice_retrig),
      .steal        (steal)
   );

   function automatic logic [15:0] mk(input logic [1:0] op, input logic [6:0] n, input logic [6:0] v);
      return {op, n, v};
   endfunction

   function automatic logic [6:0] note_of(input int i);
      return voice_note[7*i +: 7];
   endfunction

   function automatic logic [9:0] amp_of(input int i);
      return voice_amp[10*i +: 10];
   endfunction

   task automatic do_reset();
      cmd_valid = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Present one command; returns at the negedge just after the accept edge
   task automatic issue(input logic [15:0] w);
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 32) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         n_vec++; n_err++;
         $display("FAIL issue_timeout: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_data = w;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      $display("cmd %h issued at %0t", w, $time);
   endtask

   // Issue and land in the cycle right after the commit edge (E0+5)
   task automatic play(input logic [15:0] w);
      issue(w);
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
      n_vec++; if (voice_gate !== 4'b0) begin n_err++; $display("FAIL rst_gate: got %b want 0000", voice_gate); end
      n_vec++; if (voice_note !== 28'b0) begin n_err++; $display("FAIL rst_note: got %h want 0", voice_note); end
      n_vec++; if (voice_amp !== 40'b0) begin n_err++; $display("FAIL rst_amp: got %h want 0", voice_amp); end
      n_vec++; if (voice_retrig !== 4'b0) begin n_err++; $display("FAIL rst_retrig: got %b want 0000", voice_retrig); end
      n_vec++; if (steal !== 1'b0) begin n_err++; $display("FAIL rst_steal: got %b want 0", steal); end
   endtask

   task automatic test_note_on();
      issue(16'h5E64);
      repeat (4) @(negedge clk);
      n_vec++; if (voice_gate !== 4'b0000) begin n_err++; $display("FAIL on_early_gate: got %b want 0000", voice_gate); end
      n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL on_busy_ready: got %b want 0", cmd_ready); end
      @(negedge clk);
      n_vec++; if (voice_gate !== 4'b0001) begin n_err++; $display("FAIL on_gate: got %b want 0001", voice_gate); end
      n_vec++; if (note_of(0) !== 7'd60) begin n_err++; $display("FAIL on_note0: got %0d want 60", note_of(0)); end
      n_vec++; if (amp_of(0) !== 10'd806) begin n_err++; $display("FAIL on_amp0: got %0d want 806", amp_of(0)); end
      n_vec++; if (voice_retrig !== 4'b0001) begin n_err++; $display("FAIL on_retrig: got %b want 0001", voice_retrig); end
      n_vec++; if (steal !== 1'b0) begin n_err++; $display("FAIL on_steal: got %b want 0", steal); end
      n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL on_ready: got %b want 1", cmd_ready); end
      @(negedge clk);
      n_vec++; if (voice_retrig !== 4'b0000) begin n_err++; $display("FAIL on_retrig_end: got %b want 0000", voice_retrig); end
   endtask

   task automatic test_steal();
      do_reset();
      play(mk(2'b01, 7'd60, 7'd100));
      play(mk(2'b01, 7'd62, 7'd100));
      play(mk(2'b01, 7'd64, 7'd100));
      play(mk(2'b01, 7'd65, 7'd100));
      n_vec++; if (voice_retrig !== 4'b1000) begin n_err++; $display("FAIL fill_retrig: got %b want 1000", voice_retrig); end
      n_vec++; if (steal !== 1'b0) begin n_err++; $display("FAIL fill_steal: got %b want 0", steal); end
      play(mk(2'b01, 7'd67, 7'd100));
      n_vec++; if (steal !== 1'b1) begin n_err++; $display("FAIL steal_pulse: got %b want 1", steal); end
      n_vec++; if (voice_retrig !== 4'b0001) begin n_err++; $display("FAIL steal_retrig: got %b want 0001", voice_retrig); end
      n_vec++; if (note_of(0) !== 7'd67) begin n_err++; $display("FAIL steal_note0: got %0d want 67", note_of(0)); end
      n_vec++; if (voice_note[27:7] !== {7'd65, 7'd64, 7'd62}) begin n_err++; $display("FAIL steal_others: got %h want %h", voice_note[27:7], {7'd65, 7'd64, 7'd62}); end
      n_vec++; if (voice_gate !== 4'b1111) begin n_err++; $display("FAIL steal_gate: got %b want 1111", voice_gate); end
      @(negedge clk);
      n_vec++; if ({steal, voice_retrig} !== 5'b0) begin n_err++; $display("FAIL steal_end: got %b want 00000", {steal, voice_retrig}); end
      play(mk(2'b01, 7'd69, 7'd100));
      n_vec++; if (voice_retrig !== 4'b0010) begin n_err++; $display("FAIL steal2_retrig: got %b want 0010", voice_retrig); end
      n_vec++; if (steal !== 1'b1) begin n_err++; $display("FAIL steal2_pulse: got %b want 1", steal); end
      n_vec++; if (note_of(1) !== 7'd69) begin n_err++; $display("FAIL steal2_note1: got %0d want 69", note_of(1)); end
   endtask

   task automatic test_retrig_same();
      do_reset();
      play(mk(2'b01, 7'd60, 7'd100));
      play(mk(2'b01, 7'd62, 7'd100));
      play(mk(2'b01, 7'd62, 7'd127));
      n_vec++; if (voice_retrig !== 4'b0010) begin n_err++; $display("FAIL same_retrig: got %b want 0010", voice_retrig); end
      n_vec++; if (amp_of(1) !== 10'd1023) begin n_err++; $display("FAIL same_amp1: got %0d want 1023", amp_of(1)); end
      n_vec++; if (voice_gate !== 4'b0011) begin n_err++; $display("FAIL same_gate: got %b want 0011", voice_gate); end
      n_vec++; if (note_of(1) !== 7'd62) begin n_err++; $display("FAIL same_note1: got %0d want 62", note_of(1)); end
      n_vec++; if (amp_of(0) !== 10'd806) begin n_err++; $display("FAIL same_amp0: got %0d want 806", amp_of(0)); end
      n_vec++; if (note_of(2) !== 7'd0) begin n_err++; $display("FAIL same_note2: got %0d want 0", note_of(2)); end
      n_vec++; if (steal !== 1'b0) begin n_err++; $display("FAIL same_steal: got %b want 0", steal); end
   endtask

   task automatic test_note_off();
      do_reset();
      play(mk(2'b01, 7'd60, 7'd100));
      play(mk(2'b01, 7'd62, 7'd100));
      play(mk(2'b01, 7'd64, 7'd100));
      play(mk(2'b01, 7'd65, 7'd100));
      play(16'hA000);
      n_vec++; if (voice_gate !== 4'b1011) begin n_err++; $display("FAIL off_gate: got %b want 1011", voice_gate); end
      n_vec++; if (note_of(2) !== 7'd64) begin n_err++; $display("FAIL off_note2: got %0d want 64", note_of(2)); end
      n_vec++; if (amp_of(2) !== 10'd806) begin n_err++; $display("FAIL off_amp2: got %0d want 806", amp_of(2)); end
      n_vec++; if (voice_retrig !== 4'b0000) begin n_err++; $display("FAIL off_retrig: got %b want 0000", voice_retrig); end
      play(mk(2'b10, 7'd70, 7'd0));
      n_vec++; if (voice_gate !== 4'b1011) begin n_err++; $display("FAIL off_nomatch: got %b want 1011", voice_gate); end
      play(mk(2'b01, 7'd65, 7'd0));
      n_vec++; if (voice_gate !== 4'b0011) begin n_err++; $display("FAIL vel0_gate: got %b want 0011", voice_gate); end
      n_vec++; if (voice_retrig !== 4'b0000) begin n_err++; $display("FAIL vel0_retrig: got %b want 0000", voice_retrig); end
      play(mk(2'b01, 7'd66, 7'd100));
      n_vec++; if (voice_gate !== 4'b0111) begin n_err++; $display("FAIL refill_gate: got %b want 0111", voice_gate); end
      n_vec++; if (note_of(2) !== 7'd66) begin n_err++; $display("FAIL refill_note2: got %0d want 66", note_of(2)); end
      n_vec++; if (voice_retrig !== 4'b0100) begin n_err++; $display("FAIL refill_retrig: got %b want 0100", voice_retrig); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge clk);
      cmd_data = mk(2'b01, 7'd60, 7'd100);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_data = mk(2'b01, 7'd62, 7'd100);
      $display("cmd %h issued, next %h held", mk(2'b01, 7'd60, 7'd100), cmd_data);
      for (int k = 1; k <= 5; k++) begin
         n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy%0d: got %b want 0", k, cmd_ready); end
         if (k < 5) @(negedge clk);
      end
      @(negedge clk);
      n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", cmd_ready); end
      n_vec++; if (voice_gate !== 4'b0001) begin n_err++; $display("FAIL b2b_first: got %b want 0001", voice_gate); end
      @(negedge clk);
      n_vec++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept2: got %b want 0", cmd_ready); end
      cmd_valid = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++; if (voice_gate !== 4'b0011) begin n_err++; $display("FAIL b2b_gate: got %b want 0011", voice_gate); end
      n_vec++; if (note_of(1) !== 7'd62) begin n_err++; $display("FAIL b2b_note1: got %0d want 62", note_of(1)); end
      n_vec++; if (voice_retrig !== 4'b0010) begin n_err++; $display("FAIL b2b_retrig: got %b want 0010", voice_retrig); end
   endtask

   task automatic test_all_off();
      play(mk(2'b01, 7'd64, 7'd100));
      n_vec++; if (voice_gate !== 4'b0111) begin n_err++; $display("FAIL alloff_pre: got %b want 0111", voice_gate); end
      @(negedge clk);
      cmd_data = 16'hC000;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      $display("cmd %h issued at %0t", cmd_data, $time);
      n_vec++; if (voice_gate !== 4'b0000) begin n_err++; $display("FAIL alloff_gate: got %b want 0000", voice_gate); end
      n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL alloff_ready: got %b want 1", cmd_ready); end
      n_vec++; if (note_of(0) !== 7'd60) begin n_err++; $display("FAIL alloff_note0: got %0d want 60", note_of(0)); end
      n_vec++; if (voice_retrig !== 4'b0000) begin n_err++; $display("FAIL alloff_retrig: got %b want 0000", voice_retrig); end
   endtask

   task automatic test_reset_mid_scan();
      int bad = 0;
      do_reset();
      play(mk(2'b01, 7'd60, 7'd100));
      issue(mk(2'b01, 7'd62, 7'd100));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if (voice_gate !== 4'b0000) begin n_err++; $display("FAIL midrst_gate: got %b want 0000", voice_gate); end
      n_vec++; if (note_of(0) !== 7'd0) begin n_err++; $display("FAIL midrst_note0: got %0d want 0", note_of(0)); end
      n_vec++; if (amp_of(0) !== 10'd0) begin n_err++; $display("FAIL midrst_amp0: got %0d want 0", amp_of(0)); end
      n_vec++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", cmd_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if ({steal, voice_retrig, voice_gate} !== 9'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_err++; $display("FAIL midrst_nopulse: got %0d active cycles want 0", bad); end
      play(mk(2'b01, 7'd65, 7'd100));
      n_vec++; if (voice_gate !== 4'b0001) begin n_err++; $display("FAIL midrst_after_gate: got %b want 0001", voice_gate); end
      n_vec++; if (note_of(0) !== 7'd65) begin n_err++; $display("FAIL midrst_after_note0: got %0d want 65", note_of(0)); end
   endtask

   initial begin
      test_reset();
      test_note_on();
      test_steal();
      test_retrig_same();
      test_note_off();
      test_back_to_back();
      test_all_off();
      test_reset_mid_scan();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
